// File: rtl/pwm_compare_if.sv
// Duty-value handshake between a duty producer and pwm_compare.
// The producer holds duty_in/duty_valid until duty_ready is seen high at a clock edge.
interface pwm_compare_if #(
    parameter int N = 4
);
    logic [N-1:0] duty_in;
    logic         duty_valid;
    logic         duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_compare.sv
// PWM compare stage: registered pwm/period_end from a free-running counter, with
// shadowed duty updates committed only at count==MAX. Option: PWM_PERIOD_CNT_EN adds period_cnt.
module pwm_compare #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] count,
    pwm_compare_if.slave duty,
    output logic         pwm,
    output logic         period_end,
    output logic [N-1:0] duty_active,
    output logic         duty_pending
`ifdef PWM_PERIOD_CNT_EN
    ,
    output logic [15:0]  period_cnt
`endif
);

    logic [N-1:0] shadow_q, shadow_d;
    logic [N-1:0] active_q, active_d;
    logic         pending_q, pending_d;
    logic         pwm_q, pwm_d;
    logic         pend_q, pend_d;
    logic         is_max;
    logic         accept;
    logic         commit;

    assign is_max = (count == {N{1'b1}});
    assign duty.duty_ready = !reset && !pending_q;
    assign accept = duty.duty_valid && duty.duty_ready;
    // pending_q is the pre-edge value, so a same-edge accept waits for the next MAX
    assign commit = is_max && pending_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = duty.duty_in;
            pending_d = 1'b1;
        end
        pwm_d  = (count < active_q);
        pend_d = is_max;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
            pend_q    <= pend_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_end   = pend_q;
    assign duty_active  = active_q;
    assign duty_pending = pending_q;

`ifdef PWM_PERIOD_CNT_EN
    logic [15:0] pcnt_q, pcnt_d;

    assign pcnt_d = is_max ? pcnt_q + 16'd1 : pcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt = pcnt_q;
`endif

endmodule
